// File: rtl/reg_wb_arbiter.sv
// Write-port controller for the register file: post-reset zero-fill, then NREQ-way writeback arbitration.
// Define RR_ARB_EN for round-robin grant; otherwise fixed priority (lowest index wins).
module reg_wb_arbiter #(
  parameter int NREQ  = 2,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int NREGS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               we,
  output logic [AW-1:0]      waddr,
  output logic [DW-1:0]      wdata,
  output logic               init_done
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q;
  logic [AW-1:0]   clr_ptr_q;
  logic            we_q;
  logic [AW-1:0]   waddr_q;
  logic [DW-1:0]   wdata_q;
  logic            init_done_q;
`ifdef RR_ARB_EN
  logic [IW-1:0]   rr_ptr_q;
`endif

  logic [NREQ-1:0] grant_d;
  logic [IW-1:0]   gidx_d;
  logic            found_d;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  // Grant is a function of state, req_valid and rr_ptr only; addr/data never feed it.
  always_comb begin
    grant_d = '0;
    gidx_d  = '0;
    found_d = 1'b0;
`ifdef RR_ARB_EN
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(rr_ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found_d && req_valid[j]) begin
        found_d = 1'b1;
        gidx_d  = IW'(j);
      end
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      if (!found_d && req_valid[k]) begin
        found_d = 1'b1;
        gidx_d  = IW'(k);
      end
    end
`endif
    if (state_q == RUN && !rst && found_d) grant_d[gidx_d] = 1'b1;
  end

  assign req_ready = grant_d;
  assign xfer      = |grant_d;
  assign sel_addr  = req_addr[gidx_d*AW +: AW];
  assign sel_data  = req_data[gidx_d*DW +: DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= AW'(1);
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      init_done_q <= 1'b0;
`ifdef RR_ARB_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      case (state_q)
        CLEAR: begin
          we_q      <= 1'b1;
          waddr_q   <= clr_ptr_q;
          wdata_q   <= '0;
          clr_ptr_q <= clr_ptr_q + AW'(1);
          if (clr_ptr_q == AW'(NREGS-1)) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          // A transfer to x0 is consumed but never reaches the port.
          we_q <= xfer && (sel_addr != '0);
          if (xfer && sel_addr != '0) begin
            waddr_q <= sel_addr;
            wdata_q <= sel_data;
          end
`ifdef RR_ARB_EN
          if (xfer) rr_ptr_q <= (gidx_d == IW'(NREQ-1)) ? '0 : gidx_d + IW'(1);
`endif
        end
      endcase
    end
  end

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign init_done = init_done_q;
endmodule
